ct_l2cif_dbg_read: RTL and testbench

- Downstream consumer of the PIU "other IO" L2 direct-read request: piu_l2cif_read_req, the tag/tag_ecc/data/data_ecc selects, index and way.
- Arbitrates for the L2 tag/data array port, waits the fixed array latency, captures and formats the result.
- Returns a single-cycle l2cif_piu_read_data_vld with 128-bit l2cif_piux_read_data.
- Sits in the L2 cache interface (l2cif) beside the normal pipeline arbiter; used by debug/CSR cache-inspection reads.

---
 rtl/ct_l2cif_dbg_pkg.sv | 25 ++
 rtl/ct_l2cif_dbg_read_if.sv | 45 ++++
 rtl/ct_l2cif_dbg_read_lat_cnt.sv | 21 ++
 rtl/ct_l2cif_dbg_read.sv | 113 +++++++++++
 tb/tb_ct_l2cif_dbg_read.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ct_l2cif_dbg_pkg.sv
// Shared encodings for the L2 debug direct-read path: FSM states, select types,
// index field positions and latency counter width.
package ct_l2cif_dbg_pkg;

  localparam int CNT_W     = 4;
  localparam int CHUNK_LSB = 4;
  localparam int SET_LSB   = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARB  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  typedef enum logic [1:0] {
    SEL_TAG      = 2'd0,
    SEL_TAG_ECC  = 2'd1,
    SEL_DATA     = 2'd2,
    SEL_DATA_ECC = 2'd3
  } sel_type_e;

  function automatic logic sel_is_tag(sel_type_e t);
    return (t == SEL_TAG) || (t == SEL_TAG_ECC);
  endfunction

endpackage

// File: rtl/ct_l2cif_dbg_read_if.sv
// PIU request/response, arbiter handshake and tag/data array port bundle for the
// L2 debug read block. slave = the read block, master = its environment.
interface ct_l2cif_dbg_read_if #(
  parameter int SET_W = 13,
  parameter int TAG_W = 28
);
  logic                 piu_l2cif_read_req;
  logic                 piu_l2cif_read_tag;
  logic                 piu_l2cif_read_tag_ecc;
  logic                 piu_l2cif_read_data;
  logic                 piu_l2cif_read_data_ecc;
  logic [20:0]          piu_l2cif_read_index;
  logic [3:0]           piu_l2cif_read_way;
  logic                 l2cif_dbg_arb_req;
  logic                 arb_l2cif_dbg_gnt;
  logic                 l2cif_dbg_tag_cen;
  logic                 l2cif_dbg_data_cen;
  logic [SET_W-1:0]     l2cif_dbg_set;
  logic [3:0]           l2cif_dbg_way;
  logic [1:0]           l2cif_dbg_chunk;
  logic [TAG_W+1:0]     tag_dbg_dout;
  logic [7:0]           tag_dbg_ecc_dout;
  logic [127:0]         data_dbg_dout;
  logic [31:0]          data_dbg_ecc_dout;
  logic                 l2cif_piu_read_data_vld;
  logic [127:0]         l2cif_piux_read_data;

  modport slave (
    input  piu_l2cif_read_req, piu_l2cif_read_tag, piu_l2cif_read_tag_ecc,
           piu_l2cif_read_data, piu_l2cif_read_data_ecc, piu_l2cif_read_index,
           piu_l2cif_read_way, arb_l2cif_dbg_gnt, tag_dbg_dout, tag_dbg_ecc_dout,
           data_dbg_dout, data_dbg_ecc_dout,
    output l2cif_dbg_arb_req, l2cif_dbg_tag_cen, l2cif_dbg_data_cen, l2cif_dbg_set,
           l2cif_dbg_way, l2cif_dbg_chunk, l2cif_piu_read_data_vld, l2cif_piux_read_data
  );

  modport master (
    output piu_l2cif_read_req, piu_l2cif_read_tag, piu_l2cif_read_tag_ecc,
           piu_l2cif_read_data, piu_l2cif_read_data_ecc, piu_l2cif_read_index,
           piu_l2cif_read_way, arb_l2cif_dbg_gnt, tag_dbg_dout, tag_dbg_ecc_dout,
           data_dbg_dout, data_dbg_ecc_dout,
    input  l2cif_dbg_arb_req, l2cif_dbg_tag_cen, l2cif_dbg_data_cen, l2cif_dbg_set,
           l2cif_dbg_way, l2cif_dbg_chunk, l2cif_piu_read_data_vld, l2cif_piux_read_data
  );
endinterface

// File: rtl/ct_l2cif_dbg_read_lat_cnt.sv
// Loadable down-counter timing the array read latency; o_last marks the dout sample cycle.
module ct_l2cif_dbg_read_lat_cnt
  import ct_l2cif_dbg_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_last
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                  r_cnt <= '0;
    else if (i_load)               r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_last = (r_cnt == CNT_W'(1));
endmodule

// File: rtl/ct_l2cif_dbg_read.sv
// L2 debug direct-read engine: arbitrate for the tag/data array, wait the array latency,
// format and return a 128-bit result. ECC-array reads need CT_L2CIF_DBG_ECC_EN.
module ct_l2cif_dbg_read
  import ct_l2cif_dbg_pkg::*;
#(
  parameter int SET_W    = 13,
  parameter int TAG_W    = 28,
  parameter int TAG_LAT  = 2,
  parameter int DATA_LAT = 4
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst_b,
  ct_l2cif_dbg_read_if.slave  bus
);
  logic [1:0]       r_state;
  sel_type_e        r_type;
  logic [SET_W-1:0] r_set;
  logic [3:0]       r_way;
  logic [1:0]       r_chunk;
  logic [127:0]     r_data;

  logic [3:0]       w_sel;
  logic             w_supported;
  logic             w_gnt;
  logic             w_last;
  logic [CNT_W-1:0] w_lat;
  sel_type_e        w_type;
  logic [127:0]     w_fmt;

  assign w_sel = {bus.piu_l2cif_read_tag, bus.piu_l2cif_read_tag_ecc,
                  bus.piu_l2cif_read_data, bus.piu_l2cif_read_data_ecc};

  always_comb begin
    case (w_sel)
      4'b1000: w_type = SEL_TAG;
      4'b0100: w_type = SEL_TAG_ECC;
      4'b0010: w_type = SEL_DATA;
      default: w_type = SEL_DATA_ECC;
    endcase
  end

`ifdef CT_L2CIF_DBG_ECC_EN
  assign w_supported = $onehot(w_sel);
`else
  // ECC selects have no array path in this build and take the error return
  assign w_supported = $onehot(w_sel) & ~(w_sel[2] | w_sel[0]);
`endif

  always_comb begin
    w_fmt = '0;
    case (r_type)
      SEL_TAG:      w_fmt = 128'(bus.tag_dbg_dout);
      SEL_DATA:     w_fmt = bus.data_dbg_dout;
`ifdef CT_L2CIF_DBG_ECC_EN
      SEL_TAG_ECC:  w_fmt = 128'(bus.tag_dbg_ecc_dout);
      SEL_DATA_ECC: w_fmt = 128'(bus.data_dbg_ecc_dout);
`endif
      default:      w_fmt = '0;
    endcase
  end

  assign w_gnt = (r_state == ST_ARB) && bus.arb_l2cif_dbg_gnt;
  assign w_lat = sel_is_tag(r_type) ? CNT_W'(TAG_LAT) : CNT_W'(DATA_LAT);

  ct_l2cif_dbg_read_lat_cnt u_lat_cnt (
    .i_clk      (forever_cpuclk),
    .i_rst_n    (cpurst_b),
    .i_load     (w_gnt),
    .i_load_val (w_lat),
    .i_dec      (r_state == ST_WAIT),
    .o_last     (w_last)
  );

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state <= ST_IDLE;
      r_type  <= SEL_TAG;
      r_set   <= '0;
      r_way   <= '0;
      r_chunk <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.piu_l2cif_read_req) begin
          r_set   <= bus.piu_l2cif_read_index[SET_LSB +: SET_W];
          r_way   <= bus.piu_l2cif_read_way;
          r_chunk <= bus.piu_l2cif_read_index[CHUNK_LSB +: 2];
          r_type  <= w_type;
          if (w_supported) r_state <= ST_ARB;
          else begin
            r_data  <= '0;
            r_state <= ST_RESP;
          end
        end
        ST_ARB:  if (w_gnt) r_state <= ST_WAIT;
        ST_WAIT: if (w_last) begin
          r_data  <= w_fmt;
          r_state <= ST_RESP;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.l2cif_dbg_arb_req       = (r_state == ST_ARB);
  assign bus.l2cif_dbg_tag_cen       = w_gnt &  sel_is_tag(r_type);
  assign bus.l2cif_dbg_data_cen      = w_gnt & ~sel_is_tag(r_type);
  assign bus.l2cif_dbg_set           = r_set;
  assign bus.l2cif_dbg_way           = r_way;
  assign bus.l2cif_dbg_chunk         = r_chunk;
  assign bus.l2cif_piu_read_data_vld = (r_state == ST_RESP);
  assign bus.l2cif_piux_read_data    = r_data;
endmodule

// File: tb/tb_ct_l2cif_dbg_read.sv
// Bench for ct_l2cif_dbg_read: directed table, busy/reset corner sequences and random reads
// checked against a cycle-timeline model of the request.
module tb_ct_l2cif_dbg_read;
  localparam int SET_W    = 13;
  localparam int TAG_W    = 28;
  localparam int TAG_LAT  = 2;
  localparam int DATA_LAT = 4;

  typedef struct {
    logic [3:0]       sel;    // {tag, tag_ecc, data, data_ecc}
    logic [20:0]      idx;
    logic [3:0]       way;
    int               gdly;
    logic [TAG_W+1:0] tagd;
    logic [7:0]       tecc;
    logic [127:0]     dd;
    logic [31:0]      decc;
    int               busy_k;
    bit               err;
    logic [127:0]     exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ct_l2cif_dbg_read_if #(.SET_W(SET_W), .TAG_W(TAG_W)) bus ();

  ct_l2cif_dbg_read #(.SET_W(SET_W), .TAG_W(TAG_W), .TAG_LAT(TAG_LAT), .DATA_LAT(DATA_LAT)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .bus            (bus)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rand_douts();
    bus.tag_dbg_dout      = (TAG_W+2)'(r128());
    bus.tag_dbg_ecc_dout  = 8'($urandom);
    bus.data_dbg_dout     = r128();
    bus.data_dbg_ecc_dout = $urandom;
  endtask

  // Expected result straight from the select rules and result formats
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.err = ($countones(v.sel) != 1);
`ifndef CT_L2CIF_DBG_ECC_EN
    if (v.sel[2] || v.sel[0]) r.err = 1'b1;
`endif
    if (r.err)       r.exp = '0;
    else if (v.sel[3]) r.exp = 128'(v.tagd);
    else if (v.sel[2]) r.exp = 128'(v.tecc);
    else if (v.sel[1]) r.exp = v.dd;
    else               r.exp = 128'(v.decc);
    return r;
  endfunction

  task automatic check_outs_zero(input string nm);
    chk({nm, " arb_req"}, bus.l2cif_dbg_arb_req, 0);
    chk({nm, " tag_cen"}, bus.l2cif_dbg_tag_cen, 0);
    chk({nm, " data_cen"}, bus.l2cif_dbg_data_cen, 0);
    chk({nm, " set"}, bus.l2cif_dbg_set, 0);
    chk({nm, " way"}, bus.l2cif_dbg_way, 0);
    chk({nm, " chunk"}, bus.l2cif_dbg_chunk, 0);
    chk({nm, " vld"}, bus.l2cif_piu_read_data_vld, 0);
    chk({nm, " data"}, bus.l2cif_piux_read_data, 0);
  endtask

  // Cycle k counts from the cycle after req: ARB k=1..gk, grant at gk, sample LAT later, vld next
  task automatic run(input vec_t v, input string nm);
    bit is_tag;
    int gk, sk, vk;
    is_tag = v.sel[3] | v.sel[2];
    gk = v.gdly + 1;
    sk = gk + (is_tag ? TAG_LAT : DATA_LAT);
    vk = v.err ? 1 : sk + 1;
    @(negedge clk);
    bus.piu_l2cif_read_req      = 1'b1;
    {bus.piu_l2cif_read_tag, bus.piu_l2cif_read_tag_ecc,
     bus.piu_l2cif_read_data, bus.piu_l2cif_read_data_ecc} = v.sel;
    bus.piu_l2cif_read_index    = v.idx;
    bus.piu_l2cif_read_way      = v.way;
    bus.arb_l2cif_dbg_gnt       = 1'b0;
    rand_douts();
    #1 chk({nm, " vld@req"}, bus.l2cif_piu_read_data_vld, 0);
    for (int k = 1; k <= vk + 3; k++) begin
      @(negedge clk);
      // a stray req carries an empty select so a wrong accept would answer quickly
      bus.piu_l2cif_read_req = (k == v.busy_k);
      {bus.piu_l2cif_read_tag, bus.piu_l2cif_read_tag_ecc,
       bus.piu_l2cif_read_data, bus.piu_l2cif_read_data_ecc} = (k == v.busy_k) ? 4'b0000 : 4'($urandom);
      bus.piu_l2cif_read_index = 21'($urandom);
      bus.piu_l2cif_read_way   = 4'($urandom);
      bus.arb_l2cif_dbg_gnt    = (!v.err && k == gk) || ((v.err || k > gk) && $urandom_range(0, 1) == 1);
      rand_douts();
      if (!v.err && k == sk) begin
        bus.tag_dbg_dout      = v.tagd;
        bus.tag_dbg_ecc_dout  = v.tecc;
        bus.data_dbg_dout     = v.dd;
        bus.data_dbg_ecc_dout = v.decc;
      end
      #1;
      chk($sformatf("%s vld k=%0d", nm, k), bus.l2cif_piu_read_data_vld, (k == vk));
      chk($sformatf("%s arb_req k=%0d", nm, k), bus.l2cif_dbg_arb_req, (!v.err && k <= gk));
      chk($sformatf("%s tag_cen k=%0d", nm, k), bus.l2cif_dbg_tag_cen, (!v.err && k == gk && is_tag));
      chk($sformatf("%s data_cen k=%0d", nm, k), bus.l2cif_dbg_data_cen, (!v.err && k == gk && !is_tag));
      if (k == vk)     chk({nm, " data"}, bus.l2cif_piux_read_data, v.exp);
      if (k == vk + 1) chk({nm, " data hold"}, bus.l2cif_piux_read_data, v.exp);
      if (!v.err && k <= gk) begin
        chk({nm, " set"}, bus.l2cif_dbg_set, v.idx[SET_W+5:6]);
        chk({nm, " way"}, bus.l2cif_dbg_way, v.way);
        chk({nm, " chunk"}, bus.l2cif_dbg_chunk, v.idx[5:4]);
      end
    end
    bus.piu_l2cif_read_req = 1'b0;
    bus.arb_l2cif_dbg_gnt  = 1'b0;
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    bus.piu_l2cif_read_req = 1'b0;
    {bus.piu_l2cif_read_tag, bus.piu_l2cif_read_tag_ecc,
     bus.piu_l2cif_read_data, bus.piu_l2cif_read_data_ecc} = 4'b0000;
    bus.piu_l2cif_read_index = '0;
    bus.piu_l2cif_read_way   = '0;
    bus.arb_l2cif_dbg_gnt    = 1'b0;
    rand_douts();

    //            sel      idx          way   gdly tagd              tecc   dd                                        decc           busy err exp
    tbl[0] = '{4'b1000, 21'h0_1240, 4'd5,  0, 30'h200A_BCDE,  8'h00, 128'h0,                                   32'h0,         0, 1'b0, 128'h2_00AB_CDE};
    tbl[1] = '{4'b0010, 21'h0_1270, 4'd9,  3, 30'h0,          8'h00, 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF, 32'h0,  0, 1'b0, 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF};
    tbl[2] = '{4'b1010, 21'h1F_FFFF, 4'd3, 0, 30'h3FFF_FFFF,  8'hFF, 128'h1,                                   32'h1,         0, 1'b1, 128'h0};
    tbl[3] = '{4'b0000, 21'h0_0040, 4'd1,  0, 30'h1,          8'h01, 128'h1,                                   32'h1,         0, 1'b1, 128'h0};
`ifdef CT_L2CIF_DBG_ECC_EN
    tbl[4] = '{4'b0100, 21'h0_5550, 4'd7,  1, 30'h0,          8'hA5, 128'h0,                                   32'h0,         0, 1'b0, 128'hA5};
    tbl[5] = '{4'b0001, 21'h0_2A20, 4'd2,  0, 30'h0,          8'h00, 128'h0,                                   32'h1234_5678, 0, 1'b0, 128'h1234_5678};
`else
    tbl[4] = '{4'b0100, 21'h0_5550, 4'd7,  1, 30'h0,          8'hA5, 128'h0,                                   32'h0,         0, 1'b1, 128'h0};
    tbl[5] = '{4'b0001, 21'h0_2A20, 4'd2,  0, 30'h0,          8'h00, 128'h0,                                   32'h1234_5678, 0, 1'b1, 128'h0};
`endif
    // stray req during WAIT, then stray req in the RESP cycle
    tbl[6] = '{4'b0010, 21'h0_0810, 4'd4,  0, 30'h0,          8'h00, 128'hCAFE_F00D,                           32'h0,         3, 1'b0, 128'hCAFE_F00D};
    tbl[7] = '{4'b1000, 21'h0_3300, 4'd8,  1, 30'h1555_5555,  8'h00, 128'h0,                                   32'h0,         5, 1'b0, 128'h1555_5555};
    tbl[8] = '{4'b1000, 21'h1F_FFC0, 4'd15, 2, 30'h3FFF_FFFF, 8'h00, 128'h0,                                   32'h0,         0, 1'b0, 128'h3FFF_FFFF};

    #2 check_outs_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check_outs_zero("post-reset");

    for (int i = 0; i < 9; i++) run(tbl[i], $sformatf("vec%0d", i));

    // reset in the middle of WAIT abandons the access
    @(negedge clk);
    bus.piu_l2cif_read_req = 1'b1;
    {bus.piu_l2cif_read_tag, bus.piu_l2cif_read_tag_ecc,
     bus.piu_l2cif_read_data, bus.piu_l2cif_read_data_ecc} = 4'b0010;
    bus.piu_l2cif_read_index = 21'h0_1270;
    bus.piu_l2cif_read_way   = 4'd6;
    @(negedge clk);
    bus.piu_l2cif_read_req = 1'b0;
    bus.arb_l2cif_dbg_gnt  = 1'b1;
    @(negedge clk);
    bus.arb_l2cif_dbg_gnt  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_outs_zero("midwait-rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.arb_l2cif_dbg_gnt = 1'($urandom);
      rand_douts();
      #1 chk($sformatf("after-rst vld k=%0d", k), bus.l2cif_piu_read_data_vld, 0);
      chk($sformatf("after-rst arb k=%0d", k), bus.l2cif_dbg_arb_req, 0);
    end
    bus.arb_l2cif_dbg_gnt = 1'b0;
    run(tbl[1], "after-rst-read");

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: rv.sel = 4'b1000;
        1: rv.sel = 4'b0100;
        2: rv.sel = 4'b0010;
        3: rv.sel = 4'b0001;
        default: rv.sel = 4'($urandom);
      endcase
      rv.idx    = 21'($urandom);
      rv.way    = 4'($urandom);
      rv.gdly   = $urandom_range(0, 4);
      rv.tagd   = (TAG_W+2)'(r128());
      rv.tecc   = 8'($urandom);
      rv.dd     = r128();
      rv.decc   = $urandom;
      rv.busy_k = 0;
      rv = model(rv);
      run(rv, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
